// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI controller and SPI target blocks.
package spi_pkg;

   // Clock polarity/phase combinations; the target only implements mode 0.
   typedef enum logic [1:0] {
      SPI_MODE0 = 2'd0,
      SPI_MODE1 = 2'd1,
      SPI_MODE2 = 2'd2,
      SPI_MODE3 = 2'd3
   } spi_mode_t;

   // Byte returned by a target that has nothing queued to send.
   localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: types local to the SPI target.
package spi_target_pkg;

   // IDLE: deselected. LOAD: fetch the first TX byte. SHIFT: clocking bits.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } tgt_state_t;

   localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output and occupancy count.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of two.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int              AW         = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == FULL_LEVEL);
   assign empty_o = (level_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Occupancy only changes when exactly one of push/pop is accepted.
   always_comb begin
      // NOTE: default first so every path assigns level_d and no latch is inferred.
      level_d = level_q;
      if (do_push && !do_pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         level_d = level_q - (AW+1)'(1);
      end
   end

   // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Storage array written on accepted pushes.
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; zero occupancy already makes stale entries unreachable.
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target. Bus pins are oversampled on FastClk, received
// bytes are presented on RXData/RXValid, and Do is fed from a small TX FIFO.
module spi_target
   import spi_pkg::*;
   import spi_target_pkg::*;
#(
   parameter int         TX_DEPTH    = 4,
   parameter logic [7:0] IDLE_BYTE   = SPI_IDLE_BYTE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                      FastClk,
   input  logic                      Reset,
   input  logic                      nSel,
   input  logic                      SPIClk,
   input  logic                      Di,
   output logic                      Do,
   output logic                      DoEn,
   output logic [7:0]                RXData,
   output logic                      RXValid,
   input  logic [7:0]                TXData,
   input  logic                      TXPush,
   output logic                      TXFull,
   output logic [$clog2(TX_DEPTH):0] TXLevel,
   output logic                      Underrun,
   output logic                      Aborted,
   output logic                      Busy
);
   logic [SYNC_STAGES:0]   sel_sync_q, sclk_sync_q;
   logic [SYNC_STAGES-1:0] di_sync_q;
   logic                   sel_fall, sel_rise, sel_edge, sclk_rise, sclk_fall, di_s;

   tgt_state_t             state_q, state_d;
   logic                   load_tx, shift_tx, sample_rx, end_xfer;

   logic [6:0]             tx_shift_q, tx_shift_d;
   logic [6:0]             rx_shift_q, rx_shift_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic                   do_q, do_d, doen_q, doen_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   underrun_q, underrun_d, aborted_q, aborted_d;

   logic [7:0]             fifo_head, tx_byte;
   logic                   fifo_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i   (FastClk),
      .reset_i (Reset),
      .push_i  (TXPush),
      .data_i  (TXData),
      .pop_i   (load_tx),
      .data_o  (fifo_head),
      .full_o  (TXFull),
      .empty_o (fifo_empty),
      .level_o (TXLevel)
   );

   // Synchronise the bus pins; nSel/SPIClk carry one extra stage for edge detection.
   always_ff @(posedge FastClk) begin
      if (Reset) begin
         // nSel resets to "selected" so a select held across reset raises no edge;
         // only a fresh high-then-low sequence starts the next transfer.
         sel_sync_q  <= '0;
         sclk_sync_q <= '0;
         di_sync_q   <= '0;
      end else begin
         sel_sync_q  <= {sel_sync_q[SYNC_STAGES-1:0], nSel};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], SPIClk};
         di_sync_q   <= {di_sync_q[SYNC_STAGES-2:0], Di};
      end
   end

   assign sel_fall  = ~sel_sync_q[SYNC_STAGES-1] &  sel_sync_q[SYNC_STAGES];
   assign sel_rise  =  sel_sync_q[SYNC_STAGES-1] & ~sel_sync_q[SYNC_STAGES];
   assign sel_edge  = sel_fall | sel_rise;
   assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
   assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_sync_q[SYNC_STAGES];
   assign di_s      = di_sync_q[SYNC_STAGES-1];

   // FSM state register.
   always_ff @(posedge FastClk) begin
      if (Reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: select edges move between idle and active.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (sel_fall) state_d = ST_LOAD;
         ST_LOAD:  state_d = sel_rise ? ST_IDLE : ST_SHIFT;
         ST_SHIFT: if (sel_rise) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: datapath strobes; a select edge masks any same-cycle clock edge.
   always_comb begin
      load_tx   = 1'b0;
      shift_tx  = 1'b0;
      sample_rx = 1'b0;
      end_xfer  = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            end_xfer = sel_rise;
            load_tx  = ~sel_rise;
         end
         ST_SHIFT: begin
            end_xfer = sel_rise;
            if (!sel_edge) begin
               sample_rx = sclk_rise;
               load_tx   = sclk_fall & (bit_cnt_q == '0);
               shift_tx  = sclk_fall & (bit_cnt_q != '0);
            end
         end
         default: ;
      endcase
   end

   assign tx_byte = fifo_empty ? IDLE_BYTE : fifo_head;

   // Datapath next state: TX/RX shifters, bit count and status flags.
   always_comb begin
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      do_d       = do_q;
      doen_d     = doen_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      underrun_d = underrun_q;
      aborted_d  = 1'b0;

      if (state_q == ST_IDLE && sel_fall) underrun_d = 1'b0;

      // Do holds the current bit; tx_shift holds the bits still to come.
      if (load_tx) begin
         do_d       = tx_byte[7];
         tx_shift_d = tx_byte[6:0];
         doen_d     = 1'b1;
         bit_cnt_d  = '0;
         if (fifo_empty) underrun_d = 1'b1;
      end
      if (shift_tx) begin
         do_d       = tx_shift_q[6];
         tx_shift_d = {tx_shift_q[5:0], 1'b0};
      end
      if (sample_rx) begin
         rx_shift_d = {rx_shift_q[5:0], di_s};
         bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
         if (bit_cnt_q == '1) begin
            rx_data_d  = {rx_shift_q, di_s};
            rx_valid_d = 1'b1;
         end
      end
      if (end_xfer) begin
         do_d      = 1'b1;
         doen_d    = 1'b0;
         aborted_d = (bit_cnt_q != '0);
         bit_cnt_d = '0;
      end
   end

   // Datapath registers.
   always_ff @(posedge FastClk) begin
      if (Reset) begin
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         bit_cnt_q  <= '0;
         do_q       <= 1'b1;
         doen_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         do_q       <= do_d;
         doen_q     <= doen_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         underrun_q <= underrun_d;
         aborted_q  <= aborted_d;
      end
   end

   assign Do       = do_q;
   assign DoEn     = doen_q;
   assign RXData   = rx_data_q;
   assign RXValid  = rx_valid_q;
   assign Underrun = underrun_q;
   assign Aborted  = aborted_q;
   assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: drives spi_target as an SPI mode-0 controller. A queue model of
// the TX FIFO predicts MISO bytes; expected RX bytes go into a scoreboard queue
// that a separate monitor drains on every RXValid pulse.
module tb_spi_target;
   localparam int         TX_DEPTH  = 4;
   localparam logic [7:0] IDLE_BYTE = 8'hFF;

   logic                      FastClk = 1'b0;
   logic                      Reset, nSel, SPIClk, Di, TXPush;
   logic [7:0]                TXData;
   logic                      Do, DoEn, RXValid, TXFull, Underrun, Aborted, Busy;
   logic [7:0]                RXData;
   logic [$clog2(TX_DEPTH):0] TXLevel;

   spi_target #(.TX_DEPTH(TX_DEPTH), .IDLE_BYTE(IDLE_BYTE), .SYNC_STAGES(2)) dut (
      .FastClk  (FastClk),
      .Reset    (Reset),
      .nSel     (nSel),
      .SPIClk   (SPIClk),
      .Di       (Di),
      .Do       (Do),
      .DoEn     (DoEn),
      .RXData   (RXData),
      .RXValid  (RXValid),
      .TXData   (TXData),
      .TXPush   (TXPush),
      .TXFull   (TXFull),
      .TXLevel  (TXLevel),
      .Underrun (Underrun),
      .Aborted  (Aborted),
      .Busy     (Busy)
   );

   always #5 FastClk = ~FastClk;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] model_q[$];     // bytes the TX FIFO should hold, head first
   bit         model_underrun;
   logic [7:0] cur_miso;       // byte the target should be shifting out now
   logic [7:0] exp_rx_q[$];    // scoreboard of bytes the target should receive
   logic [7:0] mon_exp;
   int         rx_seen = 0;
   int         abort_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every RXValid pulse must match the oldest outstanding expected byte.
   always @(negedge FastClk) begin
      if (RXValid === 1'b1) begin
         rx_seen++;
         if (exp_rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got RXData=%02h, required no RXValid (t=%0t)", RXData, $time);
         end else begin
            mon_exp = exp_rx_q.pop_front();
            check("rx_data", {24'd0, RXData}, {24'd0, mon_exp});
         end
      end
      if (Aborted === 1'b1) abort_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge FastClk);
   endtask

   // One byte leaves the TX FIFO at the start of a transfer and at every byte boundary.
   function automatic logic [7:0] model_pop();
      if (model_q.size() > 0) return model_q.pop_front();
      model_underrun = 1'b1;
      return IDLE_BYTE;
   endfunction

   task automatic push_tx(input logic [7:0] b);
      TXData = b;
      TXPush = 1'b1;
      if (model_q.size() < TX_DEPTH) model_q.push_back(b);
      cyc(1);
      TXPush = 1'b0;
   endtask

   task automatic begin_xfer();
      model_underrun = 1'b0;
      nSel = 1'b0;
      cur_miso = model_pop();
      cyc(8);
      check("doen_selected", DoEn, 1);
      check("busy_selected", Busy, 1);
   endtask

   // Full byte, MSB first; optionally push a TX byte in the middle of it.
   task automatic send_byte(input logic [7:0] mosi, input int half,
                            input bit push_mid, input logic [7:0] push_val);
      logic [7:0] got;
      logic [7:0] exp;
      exp = cur_miso;
      exp_rx_q.push_back(mosi);
      for (int i = 7; i >= 0; i--) begin
         Di = mosi[i];
         if (push_mid && i == 4) begin
            TXData = push_val;
            TXPush = 1'b1;
            if (model_q.size() < TX_DEPTH) model_q.push_back(push_val);
            cyc(1);
            TXPush = 1'b0;
            cyc(half - 1);
         end else begin
            cyc(half);
         end
         got[i] = Do;
         SPIClk = 1'b1;
         cyc(half);
         SPIClk = 1'b0;
      end
      cur_miso = model_pop();
      check("miso_byte", {24'd0, got}, {24'd0, exp});
   endtask

   // Clock n bits without expecting a received byte; returns the first bit seen on Do.
   task automatic partial_bits(input int n, input int half, output logic first_do);
      first_do = 1'b0;
      for (int i = 0; i < n; i++) begin
         Di = 1'($urandom);
         cyc(half);
         if (i == 0) first_do = Do;
         SPIClk = 1'b1;
         cyc(half);
         SPIClk = 1'b0;
      end
   endtask

   task automatic end_xfer(input int half);
      cyc(half);
      nSel = 1'b1;
      cyc(8);
      check("doen_idle", DoEn, 1'b0);
      check("do_idle", Do, 1'b1);
      check("busy_idle", Busy, 1'b0);
      check("underrun", Underrun, model_underrun);
      check("txlevel", TXLevel, model_q.size());
      check("rx_pending", exp_rx_q.size(), 0);
   endtask

   initial begin
      logic first_do;
      int   ab0, rx0;

      Reset = 1'b1; nSel = 1'b1; SPIClk = 1'b0; Di = 1'b0; TXPush = 1'b0; TXData = '0;
      cyc(4);
      check("reset_do", Do, 1'b1);
      check("reset_doen", DoEn, 1'b0);
      check("reset_rxdata", RXData, 8'h00);
      check("reset_rxvalid", RXValid, 1'b0);
      check("reset_txlevel", TXLevel, 0);
      check("reset_txfull", TXFull, 1'b0);
      check("reset_underrun", Underrun, 1'b0);
      check("reset_aborted", Aborted, 1'b0);
      check("reset_busy", Busy, 1'b0);
      Reset = 1'b0;
      cyc(6);

      // Basic exchange at a slow clock, ending in an underrun.
      push_tx(8'h3E); push_tx(8'hCA); push_tx(8'h04);
      check("preload_level", TXLevel, 3);
      begin_xfer();
      send_byte(8'hAB, 8, 1'b0, 8'h00);
      send_byte(8'hCD, 8, 1'b0, 8'h00);
      send_byte(8'hEF, 8, 1'b0, 8'h00);
      send_byte(8'h12, 8, 1'b0, 8'h00);
      end_xfer(8);
      check("exchange_underrun", Underrun, 1'b1);

      // Fill past capacity: the fifth push is dropped and never transmitted.
      for (int i = 1; i <= 5; i++) push_tx(8'(i * 8'h11));
      check("full_flag", TXFull, 1'b1);
      check("full_level", TXLevel, TX_DEPTH);
      begin_xfer();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 8, 1'b0, 8'h00);
      end_xfer(8);

      // Push into an empty FIFO while byte 0 is already shifting.
      begin_xfer();
      send_byte(8'($urandom), 8, 1'b1, 8'h53);
      send_byte(8'($urandom), 8, 1'b0, 8'h00);
      end_xfer(8);

      // Abort after three bits, then a clean transfer.
      push_tx(8'h5A); push_tx(8'hC3);
      begin_xfer();
      ab0 = abort_seen;
      partial_bits(3, 8, first_do);
      check("abort_first_bit", first_do, cur_miso[7]);
      cyc(8);
      nSel = 1'b1;
      cyc(8);
      check("abort_pulses", abort_seen - ab0, 1);
      check("abort_doen", DoEn, 1'b0);
      check("abort_busy", Busy, 1'b0);
      begin_xfer();
      send_byte(8'($urandom), 8, 1'b0, 8'h00);
      end_xfer(8);

      // Reset after five bits with nSel held low.
      push_tx(8'hA1); push_tx(8'hB2);
      begin_xfer();
      partial_bits(5, 8, first_do);
      cyc(2);
      Reset = 1'b1;
      cyc(3);
      check("mid_reset_do", Do, 1'b1);
      check("mid_reset_doen", DoEn, 1'b0);
      check("mid_reset_rxdata", RXData, 8'h00);
      check("mid_reset_txlevel", TXLevel, 0);
      check("mid_reset_underrun", Underrun, 1'b0);
      check("mid_reset_busy", Busy, 1'b0);
      Reset = 1'b0;
      model_q.delete();
      model_underrun = 1'b0;
      ab0 = abort_seen;
      rx0 = rx_seen;
      cyc(4);
      partial_bits(8, 8, first_do);
      cyc(8);
      check("ignored_busy", Busy, 1'b0);
      check("ignored_doen", DoEn, 1'b0);
      check("ignored_rx", rx_seen - rx0, 0);
      check("ignored_abort", abort_seen - ab0, 0);
      nSel = 1'b1;
      cyc(8);
      push_tx(8'h7E);
      begin_xfer();
      send_byte(8'($urandom), 8, 1'b0, 8'h00);
      end_xfer(8);

      // Maximum rate: 16 back-to-back random bytes with random refills.
      for (int i = 0; i < TX_DEPTH; i++) push_tx(8'($urandom));
      begin_xfer();
      for (int i = 0; i < 16; i++)
         send_byte(8'($urandom), 4, 1'($urandom_range(0, 1)), 8'($urandom));
      end_xfer(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded its time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
